uart_tx_serializer: RTL and testbench

- UART transmit bit engine that sits directly downstream of the TX byte FIFO.
- Pops bytes through the FIFO read handshake (rvalid/rready/rdata).
- Serialises each byte as start, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits on tx_o.
- Bit timing comes from an internal 16-bit NCO plus a 16x oversample counter.

---
 rtl/uart_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART TX bit engine: pops bytes from the TX FIFO and serialises start/8 data/parity/stop bits on tx_o.
// tx_o changes the cycle after a pop or terminating tick; the FIFO is only popped while idle or on the final stop tick.
module uart_tx_serializer #(
  parameter int NcoW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tx_enable_i,
  input  logic [NcoW-1:0] nco_i,
  input  logic            parity_en_i,
  input  logic            parity_odd_i,
  input  logic            stop2_i,
  input  logic            fifo_rvalid_i,
  output logic            fifo_rready_o,
  input  logic [7:0]      fifo_rdata_i,
  output logic            tx_o,
  output logic            busy_o,
  output logic            frame_done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_e;

  typedef struct packed {
    logic par_en;
    logic par_bit;
    logic stop2;
  } frame_cfg_t;

  state_e          state_q, state_d;
  logic [NcoW-1:0] acc_q, acc_d;
  logic [NcoW:0]   acc_sum;
  logic [3:0]      sub_q, sub_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      idx_q, idx_d;
  frame_cfg_t      cfg_q, cfg_d;
  logic            tx_q, tx_d;
  logic            busy_q;
  logic            armed_q;
  logic            tick;
  logic            bit_end;
  logic            last_stop;
  logic            end_of_frame;
  logic            pop;

  assign acc_sum      = {1'b0, acc_q} + {1'b0, nco_i};
  assign tick         = acc_sum[NcoW];
  assign bit_end      = tick & (sub_q == 4'd15);
  assign last_stop    = (state_q == STOP2) | ((state_q == STOP1) & ~cfg_q.stop2);
  assign end_of_frame = bit_end & last_stop;

  // armed_q keeps the pop strobe low for the first cycle after reset.
  assign fifo_rready_o = armed_q & ~rst_i & tx_enable_i & ((state_q == IDLE) | end_of_frame);
  assign pop           = fifo_rvalid_i & fifo_rready_o;
  assign frame_done_o  = end_of_frame;
  assign tx_o          = tx_q;
  assign busy_o        = busy_q;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cfg_d   = cfg_q;
    acc_d   = acc_sum[NcoW-1:0];
    sub_d   = tick ? sub_q + 4'd1 : sub_q;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = cfg_q.par_en ? PARITY : STOP1;
            tx_d    = cfg_q.par_en ? cfg_q.par_bit : 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP1;
          tx_d    = 1'b1;
        end
      end
      STOP1: begin
        if (bit_end) begin
          state_d = cfg_q.stop2 ? STOP2 : IDLE;
          tx_d    = 1'b1;
        end
      end
      STOP2: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A pop overrides the stop-bit exit, giving back-to-back frames with no idle gap.
    if (pop) begin
      state_d       = START;
      tx_d          = 1'b0;
      shift_d       = fifo_rdata_i;
      idx_d         = 3'd0;
      cfg_d.par_en  = parity_en_i;
      cfg_d.par_bit = (^fifo_rdata_i) ^ parity_odd_i;
      cfg_d.stop2   = stop2_i;
      acc_d         = '0;
      sub_d         = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sub_q   <= 4'd0;
      shift_q <= 8'h00;
      idx_q   <= 3'd0;
      cfg_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sub_q   <= sub_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      armed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: table vectors, multi-cycle corner sequences and random frames
// checked against a frame-level model (bit list + bits * cycles-per-bit timing).
module tb_uart_tx_serializer;

  logic        clk_i = 1'b0;
  logic        rst_i, tx_enable_i, parity_en_i, parity_odd_i, stop2_i;
  logic        fifo_rvalid_i, fifo_rready_o, tx_o, busy_o, frame_done_o;
  logic [15:0] nco_i;
  logic [7:0]  fifo_rdata_i;

  always #5 clk_i = ~clk_i;

  uart_tx_serializer #(.NcoW(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tx_enable_i   (tx_enable_i),
    .nco_i         (nco_i),
    .parity_en_i   (parity_en_i),
    .parity_odd_i  (parity_odd_i),
    .stop2_i       (stop2_i),
    .fifo_rvalid_i (fifo_rvalid_i),
    .fifo_rready_o (fifo_rready_o),
    .fifo_rdata_i  (fifo_rdata_i),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o)
  );

  typedef struct {
    logic [7:0] d;
    bit         pe, po, s2;
    bit         exp_par;
    int         exp_done;
  } vec_t;

  vec_t        tbl[7];
  logic [7:0]  q[$];
  logic [15:0] nco_v;
  bit          rst_v, en_v, pe_v, po_v, s2_v;
  int          cyc, checks, errors;
  logic        tx_s, busy_s, done_s, rdy_s, popped;

  // One cycle: drive inputs at the falling edge, then sample outputs and the pop decision.
  task automatic step();
    logic [7:0] pd;
    @(negedge clk_i);
    cyc++;
    rst_i         = rst_v;
    tx_enable_i   = en_v;
    parity_en_i   = pe_v;
    parity_odd_i  = po_v;
    stop2_i       = s2_v;
    nco_i         = nco_v;
    fifo_rvalid_i = (q.size() > 0);
    fifo_rdata_i  = (q.size() > 0) ? q[0] : 8'h00;
    #1;
    tx_s   = tx_o;
    busy_s = busy_o;
    done_s = frame_done_o;
    rdy_s  = fifo_rready_o;
    popped = fifo_rvalid_i & fifo_rready_o;
    if (popped) pd = q.pop_front();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_pop();
    int n;
    n = 0;
    popped = 1'b0;
    while (!popped && n < 40) begin
      step();
      n++;
    end
    chk("pop_seen", popped, 1);
  endtask

  // Line levels of a whole frame, bit 0 first, and its length in bits.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input bit pe, input bit po,
                                             input bit s2, output int len);
    logic [11:0] v;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = d;
    len    = 9;
    if (pe) begin
      v[9] = (^d) ^ po;
      len++;
    end
    len++;
    if (s2) len++;
    return v;
  endfunction

  // Called right after the pop cycle; returns at the cycle that should carry frame_done_o.
  task automatic run_frame(input logic [7:0] d, input bit pe, input bit po, input bit s2,
                           input int cpb, input int stall_at, input int stall_len,
                           input int drop_at, input bit toggle,
                           output int done_off, output logic par_seen);
    logic [11:0] bits;
    logic [15:0] nco_save;
    int          len, total;
    bits     = frame_bits(d, pe, po, s2, len);
    total    = len * cpb;
    done_off = -1;
    par_seen = 1'b0;
    for (int k = 1; k <= total; k++) begin
      if (stall_len > 0 && k == stall_at + 1) begin
        nco_save = nco_v;
        nco_v    = 16'h0000;
        for (int j = 0; j < stall_len; j++) begin
          step();
          if (j == 0 || j == stall_len - 1) begin
            chk("stall_tx", tx_s, bits[(stall_at - 1) / cpb]);
            chk("stall_done", done_s, 0);
          end
        end
        nco_v = nco_save;
      end
      if (toggle && k == cpb * 3) begin
        pe_v = ~pe_v;
        s2_v = ~s2_v;
      end
      if (k == drop_at) en_v = 1'b0;
      step();
      if (k % cpb == 1 || k % cpb == 0) begin
        chk("tx_bit", tx_s, bits[(k - 1) / cpb]);
        chk("busy", busy_s, 1);
        if (k < total) chk("rdy_mid", rdy_s, 0);
      end
      if (pe && (k - 1) / cpb == 9 && k % cpb == cpb / 2) par_seen = tx_s;
      if (done_s && done_off < 0) done_off = k;
    end
    chk("done_at", done_off, total);
  endtask

  task automatic idle_check(input string name);
    step();
    chk({name, "_tx"}, tx_s, 1);
    chk({name, "_busy"}, busy_s, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int          done_off, cpb, n, tmp;
    logic        par;
    logic [7:0]  rb[2];
    bit          rpe, rpo, rs2;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 320};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 352};
    tbl[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 352};
    tbl[3] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 384};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 352};
    tbl[5] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 352};
    tbl[6] = '{8'hFE, 1'b1, 1'b1, 1'b1, 1'b0, 384};

    checks = 0; errors = 0; cyc = 0;
    rst_v = 1'b1; en_v = 1'b1; pe_v = 1'b0; po_v = 1'b0; s2_v = 1'b0; nco_v = 16'h8000;
    rst_i = 1'b1; tx_enable_i = 1'b1; parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0;
    nco_i = 16'h8000; fifo_rvalid_i = 1'b0; fifo_rdata_i = 8'h00;

    step(); step();
    rst_v = 1'b0;
    step();
    chk("rst_tx", tx_s, 1);
    chk("rst_busy", busy_s, 0);
    chk("rst_rdy", rdy_s, 0);
    chk("rst_done", done_s, 0);

    for (int i = 0; i < 7; i++) begin
      pe_v = tbl[i].pe; po_v = tbl[i].po; s2_v = tbl[i].s2;
      q.push_back(tbl[i].d);
      wait_pop();
      run_frame(tbl[i].d, tbl[i].pe, tbl[i].po, tbl[i].s2, 32, 0, 0, 0, 1'b0, done_off, par);
      chk("tbl_done", done_off, tbl[i].exp_done);
      if (tbl[i].pe) chk("tbl_par", par, tbl[i].exp_par);
      idle_check("tbl_idle");
    end

    // Back-to-back: second pop shares the frame_done cycle.
    pe_v = 1'b0; po_v = 1'b0; s2_v = 1'b0;
    q.push_back(8'h55); q.push_back(8'h0F);
    wait_pop();
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 32, 0, 0, 0, 1'b0, done_off, par);
    chk("b2b_pop", popped, 1);
    chk("b2b_done", done_s, 1);
    run_frame(8'h0F, 1'b0, 1'b0, 1'b0, 32, 0, 0, 0, 1'b0, done_off, par);
    idle_check("b2b_idle");

    // Enable drops mid-frame with data still waiting.
    q.push_back(8'h3C); q.push_back(8'h99);
    wait_pop();
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 32, 0, 0, 100, 1'b0, done_off, par);
    chk("drop_rdy", rdy_s, 0);
    chk("drop_nopop", popped, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop_tx", tx_s, 1);
      chk("drop_busy", busy_s, 0);
      chk("drop_rdy_after", rdy_s, 0);
    end
    q.delete();
    en_v = 1'b1;

    // Reset during DATA loses the byte; the next queued byte is then sent.
    q.push_back(8'hC3); q.push_back(8'h81);
    wait_pop();
    for (int i = 0; i < 150; i++) step();
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    step();
    chk("mrst_tx", tx_s, 1);
    chk("mrst_busy", busy_s, 0);
    chk("mrst_rdy", rdy_s, 0);
    wait_pop();
    run_frame(8'h81, 1'b0, 1'b0, 1'b0, 32, 0, 0, 0, 1'b0, done_off, par);
    idle_check("mrst_idle");

    // Config toggled mid-frame must not change the frame length.
    q.push_back(8'h5A);
    wait_pop();
    run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 32, 0, 0, 0, 1'b1, done_off, par);
    chk("frz_done", done_off, 320);
    idle_check("frz_idle");
    pe_v = 1'b1; s2_v = 1'b1;
    q.push_back(8'hE1);
    wait_pop();
    run_frame(8'hE1, 1'b1, 1'b0, 1'b1, 32, 0, 0, 0, 1'b1, done_off, par);
    chk("frz2_done", done_off, 384);
    idle_check("frz2_idle");

    // NCO stalled mid-bit, then resumed.
    pe_v = 1'b0; s2_v = 1'b0;
    q.push_back(8'h33);
    wait_pop();
    run_frame(8'h33, 1'b0, 1'b0, 1'b0, 32, 40, 300, 0, 1'b0, done_off, par);
    idle_check("stall_idle");

    for (int it = 0; it < 6; it++) begin
      nco_v = 16'h1000 << $urandom_range(0, 3);
      tmp   = int'(nco_v);
      cpb   = 1048576 / tmp;
      rpe   = 1'($urandom_range(0, 1));
      rpo   = 1'($urandom_range(0, 1));
      rs2   = 1'($urandom_range(0, 1));
      n     = $urandom_range(1, 2);
      pe_v = rpe; po_v = rpo; s2_v = rs2;
      for (int f = 0; f < n; f++) begin
        rb[f] = 8'($urandom);
        q.push_back(rb[f]);
      end
      wait_pop();
      for (int f = 0; f < n; f++) begin
        run_frame(rb[f], rpe, rpo, rs2, cpb, 0, 0, 0, 1'b0, done_off, par);
        if (f < n - 1) chk("rnd_b2b", popped, 1);
      end
      idle_check("rnd_idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
